// File: rtl/hmmm_core_mc.sv
// hmmm_core_mc: parametrised multicycle HMMM core.
// FETCH/EXEC/MEM/HALT over one req/ready memory port.
module hmmm_core_mc #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              ph1,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic              illegal,
   output logic              retire,
   output logic [ADDR_W-1:0] dbg_pc
);

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, pc_inc, tgt;
   logic [15:0]       ir;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] xv, yv, zv, simm, ldata, wd;
   logic [3:0]        op, xi, yi, zi;
   logic              ir_ld, we_en, ill_set, ret_nx, taken;

   assign op     = ir[15:12];
   assign xi     = ir[11:8];
   assign yi     = ir[7:4];
   assign zi     = ir[3:0];
   assign pc_inc = pc + ADDR_W'(1);
   assign tgt    = ADDR_W'(ir[7:0]);
   assign simm   = DATA_W'(signed'(ir[7:0]));
   assign ldata  = DATA_W'(mem_rdata);
   assign halted = (state == HALT);
   assign dbg_pc = pc;

   // register read ports; r0 and out-of-range indices read zero
   always_comb begin
      xv = '0;
      yv = '0;
      zv = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (xi == 4'(i)) xv = regs[i];
         if (yi == 4'(i)) yv = regs[i];
         if (zi == 4'(i)) zv = regs[i];
      end
   end

   // conditional branch test on X as a signed value
   always_comb begin
      taken = 1'b0;
      unique case (1'b1)
         op == 4'h9: taken = (xv == '0);
         op == 4'hA: taken = (xv != '0);
         op == 4'hB: taken = !xv[DATA_W-1] && (xv != '0);
         op == 4'hC: taken = xv[DATA_W-1];
         default:    taken = 1'b0;
      endcase
   end

   // next state, memory port and writeback control
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      ir_ld     = 1'b0;
      we_en     = 1'b0;
      wd        = '0;
      ill_set   = 1'b0;
      ret_nx    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = '0;
      unique case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_ld    = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            state_nx = FETCH;
            pc_nx    = pc_inc;
            ret_nx   = 1'b1;
            unique case (op)
               4'h0: begin
                  state_nx = HALT;
                  pc_nx    = pc;
                  ret_nx   = 1'b0;
               end
               4'h1: begin
                  we_en = 1'b1;
                  wd    = simm;
               end
               4'h2: begin
                  we_en = 1'b1;
                  wd    = xv + simm;
               end
               4'h3: begin
                  we_en = 1'b1;
                  wd    = yv + zv;
               end
               4'h4: begin
                  we_en = 1'b1;
                  wd    = yv - zv;
               end
               4'h5, 4'h6: begin
                  state_nx = MEM;
                  pc_nx    = pc;
                  ret_nx   = 1'b0;
               end
               4'h7: pc_nx = tgt;
               4'h8: pc_nx = ADDR_W'(xv);
               4'h9, 4'hA, 4'hB, 4'hC: begin
                  if (taken) pc_nx = tgt;
               end
               4'hD: begin
                  we_en = 1'b1;
                  wd    = DATA_W'(pc_inc);
                  pc_nx = tgt;
               end
               default: begin
                  state_nx = HALT;
                  pc_nx    = pc;
                  ret_nx   = 1'b0;
                  ill_set  = 1'b1;
               end
            endcase
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_addr = ADDR_W'(yv);
            mem_we   = (op == 4'h6);
            if (op == 4'h6) mem_wdata = xv;
            if (mem_ready) begin
               state_nx = FETCH;
               pc_nx    = pc_inc;
               ret_nx   = 1'b1;
               if (op == 4'h5) begin
                  we_en = 1'b1;
                  wd    = ldata;
               end
            end
         end
         default: ;
      endcase
      if (reset) mem_req = 1'b0;
   end

   // architectural state; writes to r0 or beyond NREGS are dropped
   always_ff @(posedge ph1) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= '0;
         ir      <= '0;
         illegal <= 1'b0;
         retire  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         retire <= ret_nx;
         if (ir_ld) ir <= mem_rdata;
         if (ill_set) illegal <= 1'b1;
         for (int i = 1; i < NREGS; i++) begin
            if (we_en && xi == 4'(i)) regs[i] <= wd;
         end
      end
   end

endmodule
